// File: rtl/cdc_event_sched_pkg.sv
// Shared definitions for the event scheduler in front of the pulse-crossing channel:
// FSM state encoding, default sizing and the id-width helper.
package cdc_event_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } sched_state_t;

   // Smallest id width that can name every one of n sources (never below one bit).
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_NREQ  = 4;
   localparam int DEF_CNT_W = 4;
   localparam int DEF_ID_W  = id_width(DEF_NREQ);

endpackage

// File: rtl/cdc_event_sched_if.sv
// Bundle of the scheduler's control, event and crossing-side signals.
// The master side drives requests and sees the crossing increment; the slave side is the scheduler.
interface cdc_event_sched_if
   import cdc_event_sched_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int ID_W = DEF_ID_W
);

   logic            en;
   logic [NREQ-1:0] req_evt;
   logic [NREQ-1:0] ovf_clr;
   logic            xfull;
   logic            sigin;
   logic [ID_W-1:0] sig_id;
   logic [NREQ-1:0] ovf;
   logic            busy;
   logic            drained;

   modport master (
      output en, req_evt, ovf_clr, xfull,
      input  sigin, sig_id, ovf, busy, drained
   );

   modport slave (
      input  en, req_evt, ovf_clr, xfull,
      output sigin, sig_id, ovf, busy, drained
   );

endinterface

// File: rtl/cdc_event_sched_rr_pick.sv
// Combinational round-robin picker: starting at rr_ptr and wrapping after NREQ-1,
// grants the first eligible source. Produces nothing when enable is low.
module cdc_rr_pick
   import cdc_event_sched_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int ID_W = DEF_ID_W
) (
   input  logic [NREQ-1:0] elig,
   input  logic [ID_W-1:0] rr_ptr,
   input  logic            enable,
   output logic [NREQ-1:0] gnt,
   output logic [ID_W-1:0] idx
);

   logic found;
   int   cand;

   // Walk the sources in rotated order; the explicit wrap keeps non-power-of-two NREQ correct.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int i = 0; i < NREQ; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NREQ) cand = cand - NREQ;
         for (int j = 0; j < NREQ; j++) begin
            if (enable && !found && (j == cand) && elig[j]) begin
               found  = 1'b1;
               gnt[j] = 1'b1;
               idx    = ID_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/cdc_event_sched.sv
// Write-domain scheduler sharing one pulse-crossing increment among NREQ event sources.
// Keeps a saturating pending count per source, issues at most one event per cycle in
// round-robin order, stalls on crossing full and sequences enable/drain.
module cdc_event_sched
   import cdc_event_sched_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int CNT_W = DEF_CNT_W,
   parameter int ID_W  = DEF_ID_W
) (
   input  logic              wclk,
   input  logic              wrst_n,
   cdc_event_sched_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   sched_state_t     state, state_nxt;
   logic [CNT_W-1:0] cnt [NREQ];
   logic [NREQ-1:0]  elig;
   logic [NREQ-1:0]  ovf_set;
   logic [NREQ-1:0]  ovf_r;
   logic [NREQ-1:0]  gnt;
   logic [ID_W-1:0]  pick_idx;
   logic [ID_W-1:0]  rr_ptr;
   logic             any_pend;
   logic             issue;
   logic             drain_done;

   // Eligibility comes from registered counts only; an overflow is an event arriving at a full, ungranted counter.
   always_comb begin
      elig    = '0;
      ovf_set = '0;
      for (int i = 0; i < NREQ; i++) begin
         elig[i]    = (cnt[i] != '0);
         ovf_set[i] = bus.req_evt[i] && !gnt[i] && (cnt[i] == CNT_MAX);
      end
   end

   assign any_pend = |elig;
   assign issue    = ((state == ST_RUN) || (state == ST_DRAIN)) && any_pend && !bus.xfull && wrst_n;

   cdc_rr_pick #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_pick (
      .elig   (elig),
      .rr_ptr (rr_ptr),
      .enable (issue),
      .gnt    (gnt),
      .idx    (pick_idx)
   );

   // Per-source pending counters: add on event, subtract on grant, hold when both or when saturated.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_evt[i] && !gnt[i]) begin
               if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
            end else if (!bus.req_evt[i] && gnt[i]) begin
               cnt[i] <= cnt[i] - 1'b1;
            end
         end
      end
   end

   // Sticky overflow flags; a fresh overflow beats a same-cycle clear.
   always_ff @(posedge wclk) begin
      if (!wrst_n) ovf_r <= '0;
      else         ovf_r <= (ovf_r & ~bus.ovf_clr) | ovf_set;
   end

   // Round-robin pointer moves just past the granted source, holding whenever nothing issues.
   always_ff @(posedge wclk) begin
      if (!wrst_n)    rr_ptr <= '0;
      else if (issue) rr_ptr <= (pick_idx == ID_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
   end

   // FSM state register.
   always_ff @(posedge wclk) begin
      if (!wrst_n) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic: drain finishes only once counts are empty and no new event is landing; re-enable wins.
   always_comb begin
      state_nxt  = state;
      drain_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.en) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!bus.en) state_nxt = any_pend ? ST_DRAIN : ST_IDLE;
         end
         ST_DRAIN: begin
            if (bus.en) begin
               state_nxt = ST_RUN;
            end else if (!any_pend && !(|bus.req_evt)) begin
               state_nxt  = ST_IDLE;
               drain_done = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.sigin   = issue;
   assign bus.sig_id  = pick_idx;
   assign bus.ovf     = ovf_r;
   assign bus.busy    = (state != ST_IDLE);
   assign bus.drained = drain_done && wrst_n;

endmodule

// File: tb/tb_cdc_event_sched.sv
// Scenario bench for the event scheduler: a monitor logs every issued event with its cycle,
// each scenario pushes the ids it expects and compares them against the log.
module tb_cdc_event_sched;

   localparam int NREQ  = 4;
   localparam int CNT_W = 4;
   localparam int ID_W  = 2;

   typedef struct {
      int id;
      int cyc;
   } obs_t;

   logic wclk;
   logic wrst_n;

   int   vectors;
   int   miscompares;
   int   cyc;
   int   idle_id_err;
   int   drained_cnt;
   int   drained_cyc;
   obs_t obs_q [$];
   int   exp_q [$];
   obs_t mon_o;

   cdc_event_sched_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

   cdc_event_sched #(
      .NREQ  (NREQ),
      .CNT_W (CNT_W),
      .ID_W  (ID_W)
   ) dut (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .bus    (bus)
   );

   // Free-running clock.
   initial begin
      wclk = 1'b0;
      forever #5 wclk = ~wclk;
   end

   // Cycle counter so issue timing can be checked.
   always @(posedge wclk) cyc = cyc + 1;

   // Monitor: log issued events and drain pulses, and note any id shown without sigin.
   always @(negedge wclk) begin
      if (bus.sigin === 1'b1) begin
         mon_o.id  = int'(bus.sig_id);
         mon_o.cyc = cyc;
         obs_q.push_back(mon_o);
      end else if (bus.sig_id !== '0) begin
         idle_id_err = idle_id_err + 1;
      end
      if (bus.drained === 1'b1) begin
         drained_cnt = drained_cnt + 1;
         drained_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic test_reset();
      obs_t o;
      int   e;
      int   prev;
      bit   first;
      bus.req_evt = 4'b1111;
      bus.en      = 1'b0;
      wrst_n      = 1'b0;
      tick();
      tick();
      @(negedge wclk);
      vectors++;
      if (bus.sigin !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sigin: got %b, expected 0", bus.sigin); end
      vectors++;
      if (bus.ovf !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_ovf: got %b, expected 0000", bus.ovf); end
      vectors++;
      if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy); end
      tick();
      wrst_n = 1'b1;
      bus.en = 1'b1;
      @(negedge wclk);
      vectors++;
      if (bus.sigin !== 1'b0) begin miscompares++; $display("[TB] FAIL release_sigin: got %b, expected 0", bus.sigin); end
      tick();
      bus.req_evt = 4'b0000;
      @(negedge wclk);
      vectors++;
      if (bus.sigin !== 1'b1 || bus.sig_id !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL release_first_issue: got sigin=%b id=%0d, expected sigin=1 id=0", bus.sigin, bus.sig_id);
      end
      for (int k = 0; k < NREQ; k++) exp_q.push_back(k);
      for (int k = 0; k < 5; k++) tick();
      bus.en = 1'b0;
      tick();
      tick();
      first = 1'b1;
      prev  = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("[TB] FAIL reset_seq: got no issue, expected id=%0d", e);
         end else begin
            o = obs_q.pop_front();
            if (o.id !== e) begin miscompares++; $display("[TB] FAIL reset_seq: got id=%0d, expected id=%0d", o.id, e); end
            else if (!first && o.cyc !== prev + 1) begin miscompares++; $display("[TB] FAIL reset_seq_b2b: got cycle %0d, expected %0d", o.cyc, prev + 1); end
            prev  = o.cyc;
            first = 1'b0;
         end
      end
      vectors++;
      if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL reset_extra: got %0d extra issues, expected 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_round_robin();
      obs_t o;
      int   e;
      int   prev;
      int   pulse_cyc;
      bit   first;
      bus.en = 1'b1;
      tick();
      bus.req_evt = 4'b1111;
      pulse_cyc   = cyc;
      tick();
      bus.req_evt = 4'b1001;
      tick();
      bus.req_evt = 4'b0000;
      for (int k = 0; k < 6; k++) tick();
      vectors++;
      if (obs_q.size() == 0 || obs_q[0].cyc !== pulse_cyc + 1) begin
         miscompares++;
         $display("[TB] FAIL rr_latency: got first issue cycle %0d, expected %0d", (obs_q.size() == 0) ? -1 : obs_q[0].cyc, pulse_cyc + 1);
      end
      exp_q = '{0, 1, 2, 3, 0, 3};
      first = 1'b1;
      prev  = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("[TB] FAIL rr_order: got no issue, expected id=%0d", e);
         end else begin
            o = obs_q.pop_front();
            if (o.id !== e) begin miscompares++; $display("[TB] FAIL rr_order: got id=%0d, expected id=%0d", o.id, e); end
            else if (!first && o.cyc !== prev + 1) begin miscompares++; $display("[TB] FAIL rr_b2b: got cycle %0d, expected %0d", o.cyc, prev + 1); end
            prev  = o.cyc;
            first = 1'b0;
         end
      end
      vectors++;
      if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL rr_extra: got %0d extra issues, expected 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_xfull();
      obs_t o;
      int   e;
      int   prev;
      bit   first;
      bus.xfull = 1'b1;
      for (int k = 0; k < 10; k++) begin
         bus.req_evt = (k == 1 || k == 4 || k == 7) ? 4'b0100 : 4'b0000;
         tick();
      end
      bus.req_evt = 4'b0000;
      @(negedge wclk);
      vectors++;
      if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL xfull_block: got %0d issues, expected 0", obs_q.size()); obs_q.delete(); end
      tick();
      bus.xfull = 1'b0;
      for (int k = 0; k < 3; k++) exp_q.push_back(2);
      for (int k = 0; k < 6; k++) tick();
      first = 1'b1;
      prev  = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("[TB] FAIL xfull_release: got no issue, expected id=%0d", e);
         end else begin
            o = obs_q.pop_front();
            if (o.id !== e) begin miscompares++; $display("[TB] FAIL xfull_release: got id=%0d, expected id=%0d", o.id, e); end
            else if (!first && o.cyc !== prev + 1) begin miscompares++; $display("[TB] FAIL xfull_b2b: got cycle %0d, expected %0d", o.cyc, prev + 1); end
            prev  = o.cyc;
            first = 1'b0;
         end
      end
      vectors++;
      if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL xfull_extra: got %0d extra issues, expected 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_overflow();
      obs_t o;
      int   e;
      int   prev;
      bit   first;
      bus.xfull = 1'b1;
      for (int k = 0; k < 15; k++) begin
         bus.req_evt = 4'b0010;
         tick();
      end
      vectors++;
      if (bus.ovf !== 4'b0000) begin miscompares++; $display("[TB] FAIL ovf_at_max: got %b, expected 0000", bus.ovf); end
      tick();
      vectors++;
      if (bus.ovf !== 4'b0010) begin miscompares++; $display("[TB] FAIL ovf_set: got %b, expected 0010", bus.ovf); end
      tick();
      bus.ovf_clr = 4'b0010;
      tick();
      vectors++;
      if (bus.ovf !== 4'b0010) begin miscompares++; $display("[TB] FAIL ovf_set_wins: got %b, expected 0010", bus.ovf); end
      bus.req_evt = 4'b0000;
      tick();
      bus.ovf_clr = 4'b0000;
      vectors++;
      if (bus.ovf !== 4'b0000) begin miscompares++; $display("[TB] FAIL ovf_clear: got %b, expected 0000", bus.ovf); end
      bus.xfull = 1'b0;
      for (int k = 0; k < 15; k++) exp_q.push_back(1);
      for (int k = 0; k < 20; k++) tick();
      first = 1'b1;
      prev  = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("[TB] FAIL ovf_drain: got no issue, expected id=%0d", e);
         end else begin
            o = obs_q.pop_front();
            if (o.id !== e) begin miscompares++; $display("[TB] FAIL ovf_drain: got id=%0d, expected id=%0d", o.id, e); end
            else if (!first && o.cyc !== prev + 1) begin miscompares++; $display("[TB] FAIL ovf_b2b: got cycle %0d, expected %0d", o.cyc, prev + 1); end
            prev  = o.cyc;
            first = 1'b0;
         end
      end
      vectors++;
      if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL ovf_extra: got %0d extra issues, expected 15 total", obs_q.size() + 15); obs_q.delete(); end
   endtask

   task automatic test_drain();
      obs_t o;
      int   e;
      int   prev;
      int   base_drained;
      bit   first;
      base_drained = drained_cnt;
      bus.xfull = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bus.req_evt = 4'b1000;
         tick();
      end
      bus.req_evt = 4'b0000;
      bus.en      = 1'b0;
      bus.xfull   = 1'b0;
      tick();
      @(negedge wclk);
      vectors++;
      if (bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_busy: got %b, expected 1", bus.busy); end
      for (int k = 0; k < 5; k++) exp_q.push_back(3);
      for (int k = 0; k < 8; k++) tick();
      first = 1'b1;
      prev  = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("[TB] FAIL drain_seq: got no issue, expected id=%0d", e);
         end else begin
            o = obs_q.pop_front();
            if (o.id !== e) begin miscompares++; $display("[TB] FAIL drain_seq: got id=%0d, expected id=%0d", o.id, e); end
            else if (!first && o.cyc !== prev + 1) begin miscompares++; $display("[TB] FAIL drain_b2b: got cycle %0d, expected %0d", o.cyc, prev + 1); end
            prev  = o.cyc;
            first = 1'b0;
         end
      end
      vectors++;
      if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL drain_extra: got %0d extra issues, expected 0", obs_q.size()); obs_q.delete(); end
      vectors++;
      if (drained_cnt - base_drained !== 1) begin miscompares++; $display("[TB] FAIL drained_count: got %0d pulses, expected 1", drained_cnt - base_drained); end
      vectors++;
      if (drained_cyc !== prev + 1) begin miscompares++; $display("[TB] FAIL drained_cycle: got cycle %0d, expected %0d", drained_cyc, prev + 1); end
      vectors++;
      if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_idle_busy: got %b, expected 0", bus.busy); end
   endtask

   task automatic test_reset_mid_drain();
      obs_t o;
      int   e;
      int   prev;
      int   base_drained;
      bit   first;
      base_drained = drained_cnt;
      bus.en    = 1'b1;
      bus.xfull = 1'b1;
      tick();
      for (int k = 0; k < 16; k++) begin
         bus.req_evt = (k < 3) ? 4'b0101 : 4'b0100;
         tick();
      end
      bus.req_evt = 4'b0000;
      vectors++;
      if (bus.ovf !== 4'b0100) begin miscompares++; $display("[TB] FAIL mid_ovf_set: got %b, expected 0100", bus.ovf); end
      bus.en    = 1'b0;
      bus.xfull = 1'b0;
      tick();
      tick();
      wrst_n = 1'b0;
      @(negedge wclk);
      vectors++;
      if (bus.sigin !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_sigin: got %b, expected 0", bus.sigin); end
      vectors++;
      if (bus.drained !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_drained: got %b, expected 0", bus.drained); end
      tick();
      wrst_n = 1'b1;
      bus.en = 1'b1;
      vectors++;
      if (bus.ovf !== 4'b0000) begin miscompares++; $display("[TB] FAIL mid_reset_ovf: got %b, expected 0000", bus.ovf); end
      vectors++;
      if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_state: got busy=%b, expected 0", bus.busy); end
      for (int k = 0; k < 10; k++) tick();
      exp_q = '{0, 2};
      first = 1'b1;
      prev  = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         vectors++;
         if (obs_q.size() == 0) begin
            miscompares++; $display("[TB] FAIL mid_seq: got no issue, expected id=%0d", e);
         end else begin
            o = obs_q.pop_front();
            if (o.id !== e) begin miscompares++; $display("[TB] FAIL mid_seq: got id=%0d, expected id=%0d", o.id, e); end
            else if (!first && o.cyc !== prev + 1) begin miscompares++; $display("[TB] FAIL mid_b2b: got cycle %0d, expected %0d", o.cyc, prev + 1); end
            prev  = o.cyc;
            first = 1'b0;
         end
      end
      vectors++;
      if (obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL mid_counts_cleared: got %0d issues after reset, expected 0", obs_q.size()); obs_q.delete(); end
      vectors++;
      if (drained_cnt !== base_drained) begin miscompares++; $display("[TB] FAIL mid_no_drained: got %0d pulses, expected 0", drained_cnt - base_drained); end
      vectors++;
      if (idle_id_err !== 0) begin miscompares++; $display("[TB] FAIL sig_id_idle: got %0d nonzero ids without sigin, expected 0", idle_id_err); end
      bus.en = 1'b0;
      tick();
   endtask

   // Scenario sequence and summary.
   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      idle_id_err = 0;
      drained_cnt = 0;
      drained_cyc = -1;
      wrst_n      = 1'b0;
      bus.en      = 1'b0;
      bus.req_evt = '0;
      bus.ovf_clr = '0;
      bus.xfull   = 1'b0;
      $display("[TB] starting cdc_event_sched scenarios");
      test_reset();
      test_round_robin();
      test_xfull();
      test_overflow();
      test_drain();
      test_reset_mid_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Watchdog so the run always ends on its own.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout at cycle %0d, expected scenarios complete", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/cdc_event_sched.md
Name: cdc_event_sched

Overview:
- Write-domain (wclk) scheduler that shares one single-bit gray-pointer pulse-crossing channel among NREQ event sources.
- Counts pending events per source and issues at most one event per cycle onto the crossing's increment input.
- Uses round-robin arbitration and never issues while the crossing reports full.
- Provides enable/drain sequencing, a per-source id sideband and sticky overflow flags.

Parameters:
- NREQ, 4, number of event sources (2..8).
- CNT_W, 4, width of each per-source pending counter; saturates at 2^CNT_W-1.
- ID_W, 2, width of sig_id; must satisfy 2^ID_W >= NREQ.

Ports:
- wclk  in  1  write-domain clock.
- wrst_n  in  1  reset; synchronous, active-low; clock wclk.
- en  in  1  level; 1 = issue events, 0 = stop accepting new issue cycles (drain).
- req_evt  in  NREQ  single-cycle event pulses, one bit per source.
- ovf_clr  in  NREQ  write-1 clear of the matching ovf bit.
- xfull  in  1  full flag from the crossing's write side.
- sigin  out  1  increment to the crossing; high for exactly one cycle per issued event.
- sig_id  out  ID_W  index of the serviced source; valid only when sigin=1, otherwise 0.
- ovf  out  NREQ  sticky: an event was lost because the counter was saturated.
- busy  out  1  state != IDLE.
- drained  out  1  one-cycle pulse on DRAIN->IDLE.

Behaviour:
- Reset, in any cycle with wrst_n=0:
  - Counters = 0, rr_ptr = 0, ovf = 0, state = IDLE, drained = 0.
  - sigin and sig_id are forced to 0 in that same cycle (combinationally gated by wrst_n).
- Counters, per source i, every cycle: cnt[i] <= cnt[i] + req_evt[i] - gnt[i].
  - req_evt and gnt together: cnt unchanged, including when saturated; ovf not set.
  - cnt at max, req_evt=1, gnt=0: cnt stays at max and ovf[i] <= 1.
  - ovf_clr and a new overflow in the same cycle: ovf stays 1 (set wins).
- Eligibility: elig[i] = (cnt[i] != 0), using registered counts only.
  - A req_evt in cycle N can produce sigin no earlier than cycle N+1.
- Issue condition: issue = (state==RUN or state==DRAIN) and |elig and !xfull and wrst_n.
  - sigin = issue.
  - gnt = one-hot pick from the round-robin picker; all zero when issue=0.
  - sigin, sig_id and gnt are combinational from registered state plus xfull; zero added latency.
- Round robin:
  - Search order is rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
  - On issue, rr_ptr <= (granted index + 1) mod NREQ; otherwise rr_ptr holds.
  - NREQ not a power of two: wrap to 0 explicitly after NREQ-1.
- xfull=1: no issue; counters still accumulate; rr_ptr holds.
- State machine:
  - IDLE: no issue; events still counted. en=1 -> RUN.
  - RUN: issue per rules. en=0 and all cnt==0 -> IDLE. en=0 and any cnt!=0 -> DRAIN.
  - DRAIN: keeps issuing regardless of en.
    - When all cnt==0 and no req_evt this cycle: -> IDLE, drained=1 for that one cycle.
    - en=1 -> RUN; takes priority over completion.
  - Events arriving during DRAIN are counted and also drained before leaving DRAIN.
- Throughput: one event per cycle maximum; the crossing's full flag is the sole back-pressure.

Decomposition:
- Shared package:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DRAIN=2'd2.
  - Default NREQ/CNT_W/ID_W values.
  - Id-width sizing function.
- Sub-module cdc_rr_pick:
  - Combinational round-robin picker.
  - Inputs: elig, rr_ptr, enable. Outputs: one-hot gnt and encoded index.
- Counters, ovf, FSM and rr_ptr register stay in the top.

Test Plan:
1. Reset with req_evt=4'b1111 held high -> sigin=0, ovf=0, all counts 0; first cycle after release with en=1: sigin=0, then sigin=1 with sig_id=0 next cycle.
2. en=1, xfull=0, one pulse each on sources 0..3 in the same cycle -> sigin high 4 consecutive cycles, sig_id 0,1,2,3; rr_ptr ends at 0.
3. xfull=1 for 10 cycles while source 2 pulses 3 times -> no sigin during those cycles; after xfull drops, sig_id=2 issued exactly 3 times back-to-back.
4. CNT_W=4, xfull=1, source 1 pulses 17 times -> cnt[1]=15, ovf[1]=1; ovf_clr[1] clears it; releasing xfull yields exactly 15 issues.
5. en=1, 5 events queued on source 3, en dropped -> busy=1, state DRAIN, 5 issues, drained pulses once in the cycle after the 5th issue, busy=0.
6. Mid-drain wrst_n=0 for one cycle with counts nonzero -> sigin=0 that cycle, all counts/ovf cleared, state IDLE, no drained pulse.
